// File: rtl/sum_accumulator.sv
// Batch accumulator: sums a programmable number of adder results ({cout,sum})
// and presents the total, with a sticky overflow flag, through a valid/ready output.
module sum_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = N + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [4:0]       cnt_q;
    logic [4:0]       target_q;
    logic             ovf_q;

    logic [ACC_W:0]   beat_ext;
    logic [ACC_W:0]   sum_d;
    logic [4:0]       target_d;
    logic [4:0]       cnt_d;
    logic             beat;

    // One spare MSB on the adder so the carry out of the accumulator is the overflow
    assign beat_ext = (ACC_W + 1)'({in_cout, in_sum});
    assign sum_d    = {1'b0, acc_q} + beat_ext;
    assign target_d = (len == 4'd0) ? 5'd16 : {1'b0, len};
    assign cnt_d    = cnt_q + 5'd1;
    assign beat     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            ovf_q    <= 1'b0;
        end else if (clr) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        target_q <= target_d;
                        acc_q    <= beat_ext[ACC_W-1:0];
                        ovf_q    <= 1'b0;
                        cnt_q    <= 5'd1;
                        state_q  <= (target_d == 5'd1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q <= sum_d[ACC_W-1:0];
                        cnt_q <= cnt_d;
                        if (sum_d[ACC_W]) ovf_q <= 1'b1;
                        if (cnt_d == target_q) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_total = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid & ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench: two instances (ACC_W=9 and ACC_W=5) share stimulus; a width-aware
// model pushes expected totals per batch and they are popped when the output handshakes.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, in_cout, out_ready;
    logic [3:0] len, in_sum;
    logic       in_ready, out_valid, out_ovf, busy;
    logic [8:0] out_total;
    logic       in_ready5, out_valid5, out_ovf5, busy5;
    logic [4:0] out_total5;

    typedef struct {
        int t9;
        bit o9;
        int t5;
        bit o5;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] bv[16];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .in_valid(in_valid),
        .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid),
        .out_ready(out_ready), .out_total(out_total), .out_ovf(out_ovf), .busy(busy));

    sum_accumulator #(.N(4), .ACC_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .in_valid(in_valid),
        .in_ready(in_ready5), .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid5),
        .out_ready(out_ready), .out_total(out_total5), .out_ovf(out_ovf5), .busy(busy5));

    function automatic void model(input int nb, input int w, output int tot, output bit ovf);
        int acc, s;
        acc = int'(bv[0]);
        ovf = 1'b0;
        for (int i = 1; i < nb; i++) begin
            s = acc + int'(bv[i]);
            if (s >= (1 << w)) ovf = 1'b1;
            acc = s % (1 << w);
        end
        tot = acc;
    endfunction

    // Drives nb beats from bv; len is scrambled after the first beat to prove it is ignored.
    task automatic send_batch(input int lenv, input int nb, input bit push);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_cout  = bv[i][4];
            in_sum   = bv[i][3:0];
            len      = (i == 0) ? 4'(lenv) : 4'(lenv) ^ 4'(i * 5 + 3);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL beat_ready beat %0d: in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (push) begin
            model(nb, 9, e.t9, e.o9);
            model(nb, 5, e.t5, e.o5);
            sb.push_back(e);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL latency: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
            end
        end
    endtask

    task automatic collect();
        exp_t e;
        int   waited = 0;
        while (out_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL collect_timeout: out_valid=%b queued=%0d", out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (int'(out_total) !== e.t9 || out_ovf !== e.o9) begin
            n_err++;
            $display("FAIL total9: got %0d/%b required %0d/%b", out_total, out_ovf, e.t9, e.o9);
        end
        n_cmp++;
        if (int'(out_total5) !== e.t5 || out_ovf5 !== e.o5 || out_valid5 !== 1'b1) begin
            n_err++;
            $display("FAIL total5: got %0d/%b v=%b required %0d/%b", out_total5, out_ovf5,
                     out_valid5, e.t5, e.o5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL return_idle: out_valid=%b busy=%b in_ready=%b required 0/0/1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_cout = 1'b0;
        in_sum = '0; len = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_total !== 9'd0 || out_ovf !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: v=%b tot=%0d ovf=%b busy=%b rdy=%b required 0/0/0/0/1",
                     out_valid, out_total, out_ovf, busy, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bv[0] = 5'h05; bv[1] = 5'h1F; bv[2] = 5'h10;
        send_batch(3, 3, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_done: busy=%b required 1", busy);
        end
        collect();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) bv[i] = 5'h1F;
        send_batch(0, 16, 1'b1);
        collect();
    endtask

    task automatic test_overflow();
        bv[0] = 5'h1F; bv[1] = 5'h1F;
        send_batch(2, 2, 1'b1);
        collect();
        bv[0] = 5'h03;
        send_batch(1, 1, 1'b1);
        collect();
    endtask

    task automatic test_random();
        int nb;
        for (int r = 0; r < 4; r++) begin
            nb = $urandom_range(1, 16);
            for (int i = 0; i < nb; i++) bv[i] = 5'($urandom_range(0, 31));
            send_batch(nb % 16, nb, 1'b1);
            collect();
        end
    endtask

    task automatic test_backpressure();
        bv[0] = 5'h04; bv[1] = 5'h11;
        send_batch(2, 2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_sum   = 4'hA;
            in_cout  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_total) !== 21 ||
                out_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure cyc %0d: v=%b rdy=%b tot=%0d ovf=%b required 1/0/21/0",
                         c, out_valid, in_ready, out_total, out_ovf);
            end
        end
        in_valid = 1'b0;
        collect();
    endtask

    task automatic test_reset_mid();
        bv[0] = 5'h09; bv[1] = 5'h12;
        send_batch(4, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_total !== 9'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: busy=%b v=%b tot=%0d rdy=%b required 0/0/0/1",
                     busy, out_valid, out_total, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bv[0] = 5'h07;
        send_batch(1, 1, 1'b1);
        collect();
    endtask

    task automatic test_clr();
        bv[0] = 5'h0B; bv[1] = 5'h06;
        send_batch(4, 2, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_sum   = 4'h9;
        in_cout  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_drop: busy=%b v=%b required 0/0", busy, out_valid);
        end
        bv[0] = 5'h01; bv[1] = 5'h02;
        send_batch(2, 2, 1'b1);
        collect();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_clr();
        test_random();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, meaning the adder result width (sum bits, excluding carry).
REQ-002 SHALL have parameter ACC_W, default N+5, meaning the accumulator width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous batch abort.
REQ-006 SHALL have port len, input, 4, batch length; sampled on the first beat of a batch; 0 means 16.
REQ-007 SHALL have port in_valid, input, 1, upstream adder result valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 SHALL have port in_sum, input, N, adder sum.
REQ-010 SHALL have port in_cout, input, 1, adder carry-out.
REQ-011 SHALL have port out_valid, output, 1, batch total available.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the total.
REQ-013 SHALL have port out_total, output, ACC_W, batch total.
REQ-014 SHALL have port out_ovf, output, 1, overflow flag for the batch.
REQ-015 SHALL have port busy, output, 1, high in ACCUM or DONE.

Function
REQ-016 SHALL treat each beat value as the zero-extended N+1-bit value {in_cout, in_sum}.
REQ-017 SHALL transfer a beat only on a rising edge where in_valid and in_ready are both 1.
REQ-018 SHALL transfer the output only on a rising edge where out_valid and out_ready are both 1.
REQ-019 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-020 In IDLE, SHALL drive in_ready=1 and out_valid=0.
REQ-021 On the first beat in IDLE, SHALL latch target = (len==0 ? 16 : len), load acc = value, clear ovf and set cnt=1.
REQ-022 From IDLE on the first beat, SHALL go to DONE if target is 1, otherwise to ACCUM.
REQ-023 In ACCUM, SHALL drive in_ready=1, and on each beat SHALL set acc = (acc+value) mod 2^ACC_W and cnt = cnt+1.
REQ-024 In ACCUM, SHALL set ovf sticky-high whenever acc+value is at least 2^ACC_W.
REQ-025 In ACCUM, SHALL enter DONE on the beat where cnt reaches target.
REQ-026 In DONE, SHALL drive in_ready=0 and out_valid=1.
REQ-027 In DONE, SHALL hold out_total=acc and out_ovf=ovf stable until the output handshake, then return to IDLE.
REQ-028 SHALL produce out_valid high in the cycle immediately after the edge that accepts the last beat (latency 1).
REQ-029 SHALL not accept a beat in the same cycle as an output handshake (no overlap, since in_ready is 0 in DONE).
REQ-030 SHALL ignore changes on len after the first beat of a batch.
REQ-031 When clr is 1 at a rising edge, in any state, SHALL go to IDLE with acc, cnt and ovf cleared and no beat accepted that edge.
REQ-032 clr SHALL take priority over both handshakes.
REQ-033 With default ACC_W, SHALL never assert out_ovf, since 16*(2^(N+1)-1) < 2^(N+5).
REQ-034 SHALL drive all outputs as combinational functions of state and registers only.

Reset
REQ-035 While rst_n=0, SHALL immediately force state IDLE and acc=0, cnt=0, ovf=0.
REQ-036 While rst_n=0, SHALL drive out_valid=0, out_total=0, out_ovf=0, busy=0 and in_ready=1.
REQ-037 After reset, a partially accumulated batch SHALL be discarded, with no output produced for it.

Verification (N=4, ACC_W=9 unless stated)
REQ-038 Basic batch: len=3, beats {0,5},{1,15},{1,0} (cout,sum) -> out_total=52, out_ovf=0, out_valid one cycle after the 3rd beat.
REQ-039 Full batch: len=0, 16 beats of {1,15} -> out_total=496, out_ovf=0; in_ready=0 while out_valid=1.
REQ-040 Overflow (ACC_W=5): len=2, beats {1,15},{1,15} -> out_total=30, out_ovf=1; next batch len=1 {0,3} -> 3, out_ovf=0.
REQ-041 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_total, out_ovf stable and in_valid beats not accepted; out_ready=1 -> IDLE next cycle.
REQ-042 Reset mid-batch: rst_n low asynchronously after 2 of 4 beats -> outputs 0 without a clock edge; then len=1 {0,7} -> out_total=7.
REQ-043 clr mid-batch with in_valid=1 on the same edge: that beat is dropped; next batch len=2 {0,1},{0,2} -> out_total=3.
